// File: rtl/flash_pkg.sv
// Shared flash definitions: arbiter state encoding, SPI flash opcodes and
// default address/byte-count widths used by the arbiter and the controller.
package flash_pkg;

  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_NB_W   = 32;

  localparam logic [7:0] OP_READ_STATUS  = 8'h05;
  localparam logic [7:0] OP_WRITE_ENABLE = 8'h06;
  localparam logic [7:0] OP_PAGE_PROGRAM = 8'h02;
  localparam logic [7:0] OP_READ_DATA    = 8'h03;
  localparam logic [7:0] OP_SECTOR_ERASE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/flash_req_arbiter_if.sv
// Requester and controller-facing signal bundle of flash_req_arbiter.
// master = requesters + controller status (drivers), slave = the arbiter.
interface flash_req_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned NB_W   = 32
);
  logic [1:0]        req;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [NB_W-1:0]   req_nb0;
  logic [NB_W-1:0]   req_nb1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [1:0]        err;
  logic              ctl_read;
  logic              ctl_write;
  logic [ADDR_W-1:0] ctl_addr;
  logic [7:0]        ctl_nb_read;
  logic [NB_W-1:0]   ctl_nb_write;
  logic              ctl_idle;

  modport master (
    output req, req_wr, req_addr0, req_addr1, req_nb0, req_nb1, ctl_idle,
    input  gnt, done, err, ctl_read, ctl_write, ctl_addr, ctl_nb_read, ctl_nb_write
  );

  modport slave (
    input  req, req_wr, req_addr0, req_addr1, req_nb0, req_nb1, ctl_idle,
    output gnt, done, err, ctl_read, ctl_write, ctl_addr, ctl_nb_read, ctl_nb_write
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin pick; last_i is the index of the
// most recently granted port, so a tie goes to the other one.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = 2'b00;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = last_i ? 2'b01 : 2'b10;
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/flash_req_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the SPI flash controller.
// Optional watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_req_arbiter
  import flash_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned NB_W           = DEF_NB_W,
  parameter logic [27:0] TIMEOUT_CYCLES = 28'd100000000
) (
  input logic               clk,
  input logic               rst,
  flash_req_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        nbr_q, nbr_d;
  logic [NB_W-1:0]   nbw_q, nbw_d;
  logic [1:0]        pick;
  logic              timeout;

  rr_arb2 u_rr_arb2 (
    .req_i  (bus.req),
    .last_i (last_q),
    .pick_o (pick)
  );

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [27:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_ISSUE) begin
      wd_d = '0;
    end else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
      wd_d = wd_q + 28'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign timeout = (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) &&
                   (wd_q == TIMEOUT_CYCLES);
`else
  assign timeout = 1'b0;
`endif

  // Outputs are registered off the next-state decision, so done/err are high
  // exactly while the FSM sits in DONE and the start strobe follows ISSUE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    nbr_d   = nbr_q;
    nbw_d   = nbw_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    done_d  = 2'b00;
    err_d   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          gnt_d   = pick;
          last_d  = pick[1];
          wr_d    = pick[1] ? bus.req_wr[1] : bus.req_wr[0];
          addr_d  = pick[1] ? bus.req_addr1 : bus.req_addr0;
          nbr_d   = pick[1] ? bus.req_nb1[7:0] : bus.req_nb0[7:0];
          nbw_d   = pick[1] ? bus.req_nb1 : bus.req_nb0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        read_d  = ~wr_q;
        write_d = wr_q;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timeout) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = ST_DONE;
        end else if (!bus.ctl_idle) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (timeout) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = ST_DONE;
        end else if (bus.ctl_idle) begin
          done_d  = gnt_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      nbr_q   <= '0;
      nbw_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      nbr_q   <= nbr_d;
      nbw_q   <= nbw_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.ctl_read     = read_q;
  assign bus.ctl_write    = write_q;
  assign bus.ctl_addr     = addr_q;
  assign bus.ctl_nb_read  = nbr_q;
  assign bus.ctl_nb_write = nbw_q;

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Directed scoreboard bench for flash_req_arbiter with a simple controller
// busy/idle model; the timeout section follows FLASH_ARB_TIMEOUT_EN.
module tb_flash_req_arbiter;

  localparam int BUSY_LEN = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_req_arbiter_if #(.ADDR_W(24), .NB_W(32)) bus ();

  flash_req_arbiter #(
    .ADDR_W         (24),
    .NB_W           (32),
    .TIMEOUT_CYCLES (28'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  port;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  nbr;
    logic [31:0] nbw;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_cnt;
  bit   ctl_stuck = 1'b0;
  bit   excl_bad  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: goes busy one cycle after a start strobe, for BUSY_LEN cycles.
  always @(posedge clk) begin
    if (rst) begin
      bus.ctl_idle <= 1'b1;
      busy_cnt     <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) bus.ctl_idle <= 1'b1;
    end else if ((bus.ctl_read || bus.ctl_write) && !ctl_stuck) begin
      bus.ctl_idle <= 1'b0;
      busy_cnt     <= BUSY_LEN;
    end
  end

  always @(negedge clk) begin
    if (!rst && ((bus.ctl_read && bus.ctl_write) || bus.gnt == 2'b11)) excl_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] port, input logic wr, input logic [23:0] addr,
                      input logic [7:0] nbr, input logic [31:0] nbw, input logic [1:0] err);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.nbr = nbr; e.nbw = nbw; e.err = err;
    sb.push_back(e);
  endtask

  task automatic run_txn(input int max_wait, input bit late, input bit drop, output int lat);
    exp_t e;
    int   k;
    int   t_issue;
    bit   stable;
    lat = 0;
    k = 0;
    while (bus.gnt == 2'b00 && k < max_wait) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'(1), 64'(0));
      return;
    end
    e = sb.pop_front();
    check("gnt", 64'(bus.gnt), 64'(e.port));
    t_issue = cyc;
    check("issue_quiet", 64'({bus.ctl_read, bus.ctl_write}), 64'(0));
    if (late) begin
      bus.req_addr0 = 24'hFFFFFF;
      bus.req_addr1 = 24'hFFFFFF;
    end
    @(negedge clk);
    check("start", 64'({bus.ctl_read, bus.ctl_write}), 64'({~e.wr, e.wr}));
    check("addr", 64'(bus.ctl_addr), 64'(e.addr));
    check("nb_read", 64'(bus.ctl_nb_read), 64'(e.nbr));
    check("nb_write", 64'(bus.ctl_nb_write), 64'(e.nbw));
    @(negedge clk);
    check("start_1cyc", 64'({bus.ctl_read, bus.ctl_write}), 64'(0));
    stable = 1'b1;
    k = 0;
    while (bus.done == 2'b00 && k < 400) begin
      if (bus.ctl_addr !== e.addr || bus.gnt !== e.port) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    lat = cyc - t_issue;
    check("hold", 64'(stable), 64'(1));
    check("done", 64'(bus.done), 64'(e.port));
    check("err", 64'(bus.err), 64'(e.err));
    if (drop) bus.req = 2'b00;
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'(0));
    check("gnt_clr", 64'(bus.gnt), 64'(0));
  endtask

  initial begin
    int  lat;
    int  k;
    bit  saw_done;
    bus.req = 2'b00; bus.req_wr = 2'b00;
    bus.req_addr0 = '0; bus.req_addr1 = '0;
    bus.req_nb0 = '0; bus.req_nb1 = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({bus.gnt, bus.done, bus.err, bus.ctl_read, bus.ctl_write}), 64'(0));
    check("rst_addr", 64'(bus.ctl_addr), 64'(0));
    check("rst_nb", 64'({bus.ctl_nb_read, bus.ctl_nb_write}), 64'(0));
    rst = 1'b0;

    // Single read on port 0
    bus.req = 2'b01; bus.req_wr = 2'b00;
    bus.req_addr0 = 24'h000100; bus.req_nb0 = 32'd16;
    push(2'b01, 1'b0, 24'h000100, 8'd16, 32'd16, 2'b00);
    run_txn(1, 1'b0, 1'b1, lat);

    // Tie after reset: port 0 write first, then alternation with req held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b11; bus.req_wr = 2'b01;
    bus.req_addr0 = 24'h002000; bus.req_nb0 = 32'h00000100;
    bus.req_addr1 = 24'h003000; bus.req_nb1 = 32'h00000305;
    push(2'b01, 1'b1, 24'h002000, 8'h00, 32'h00000100, 2'b00);
    push(2'b10, 1'b0, 24'h003000, 8'h05, 32'h00000305, 2'b00);
    push(2'b01, 1'b1, 24'h002000, 8'h00, 32'h00000100, 2'b00);
    run_txn(1, 1'b0, 1'b0, lat);
    run_txn(2, 1'b0, 1'b0, lat);
    run_txn(2, 1'b0, 1'b1, lat);

    // Late address change after grant is ignored
    bus.req = 2'b01; bus.req_wr = 2'b00;
    bus.req_addr0 = 24'h004000; bus.req_nb0 = 32'd8;
    push(2'b01, 1'b0, 24'h004000, 8'd8, 32'd8, 2'b00);
    run_txn(2, 1'b1, 1'b1, lat);

    // Reset in WAIT_DONE: outputs clear, no done, port 0 wins next tie
    bus.req = 2'b10; bus.req_wr = 2'b00;
    bus.req_addr1 = 24'h005000; bus.req_nb1 = 32'd4;
    k = 0;
    while (bus.ctl_idle !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("pre_rst_gnt", 64'(bus.gnt), 64'(2'b10));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", 64'({bus.gnt, bus.done, bus.err, bus.ctl_read, bus.ctl_write}), 64'(0));
    check("mid_rst_data", 64'({bus.ctl_addr, bus.ctl_nb_read}), 64'(0));
    bus.req = 2'b00;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done !== 2'b00) saw_done = 1'b1;
    end
    check("no_done_after_rst", 64'(saw_done), 64'(0));
    bus.req = 2'b11; bus.req_wr = 2'b00;
    bus.req_addr0 = 24'h006000; bus.req_nb0 = 32'd2;
    bus.req_addr1 = 24'h007000; bus.req_nb1 = 32'd3;
    push(2'b01, 1'b0, 24'h006000, 8'd2, 32'd2, 2'b00);
    run_txn(1, 1'b0, 1'b1, lat);

    // Controller never leaves idle after the start strobe
    ctl_stuck = 1'b1;
    bus.req = 2'b10; bus.req_wr = 2'b10;
    bus.req_addr1 = 24'h008000; bus.req_nb1 = 32'h00000040;
`ifdef FLASH_ARB_TIMEOUT_EN
    push(2'b10, 1'b1, 24'h008000, 8'h40, 32'h00000040, 2'b10);
    run_txn(2, 1'b0, 1'b1, lat);
    check("wd_latency", 64'(lat >= 101 && lat <= 102), 64'(1));
`else
    @(negedge clk);
    check("stuck_gnt", 64'(bus.gnt), 64'(2'b10));
    saw_done = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done !== 2'b00 || bus.err !== 2'b00) saw_done = 1'b1;
    end
    check("stuck_no_done", 64'(saw_done), 64'(0));
    check("stuck_gnt_held", 64'(bus.gnt), 64'(2'b10));
    bus.req = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    ctl_stuck = 1'b0;

    check("excl_onehot", 64'(excl_bad), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
